// File: rtl/reservoir_level_ctrl.sv
// Reservoir fill controller: tracks level one step per qualifying edge, drives valves, flags bad sensor codes.
// Optional debounce of level steps when RESERVOIR_DEBOUNCE_EN is defined.
module reservoir_level_ctrl #(
  parameter int NUM_LEVELS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int LW             = $clog2(NUM_LEVELS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] s,
  input  logic                  fault_clr,
  output logic [NUM_LEVELS-1:0] fr,
  output logic                  dfr,
  output logic [LW-1:0]         level,
  output logic                  fault
);

  if (NUM_LEVELS < 1)      begin : g_chk_nl  $error("NUM_LEVELS must be >= 1");      end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db  $error("DEBOUNCE_CYCLES must be >= 1"); end

  logic [LW-1:0] level_q, level_d;
  logic          down_q, down_d;
  logic          fault_q, fault_d;

  logic [LW-1:0] t_lvl;
  logic          s_valid;
  logic          moving, up, step;

  // Sensed level and thermometer check: a set bit above a clear bit is a fault.
  always_comb begin
    t_lvl   = '0;
    s_valid = 1'b1;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      t_lvl = t_lvl + LW'(s[i]);
      if (i > 0 && s[i] && !s[i-1]) s_valid = 1'b0;
    end
  end

  assign moving = s_valid && (t_lvl != level_q);
  assign up     = t_lvl > level_q;

`ifdef RESERVOIR_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;

  // A reversal drops the run; the reversing edge itself is not counted.
  always_comb begin
    cnt_d = '0;
    dir_d = dir_q;
    step  = 1'b0;
    if (moving && !(cnt_q != '0 && dir_q != up)) begin
      dir_d = up;
      if (int'(cnt_q) + 1 == DEBOUNCE_CYCLES) step = 1'b1;
      else                                    cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end
`else
  assign step = moving;
`endif

  always_comb begin
    level_d = level_q;
    down_d  = down_q;
    fault_d = fault_q;
    if (!s_valid)       fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
    if (step) begin
      level_d = up ? level_q + LW'(1) : level_q - LW'(1);
      down_d  = !up;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      down_q  <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      level_q <= level_d;
      down_q  <= down_d;
      fault_q <= fault_d;
    end
  end

  // Valves open on the slots not yet covered by water.
  always_comb begin
    for (int i = 0; i < NUM_LEVELS; i++)
      fr[i] = (i < NUM_LEVELS - int'(level_q));
  end

  assign dfr   = down_q && (level_q != LW'(NUM_LEVELS));
  assign level = level_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_reservoir_level_ctrl.sv
// Bench for reservoir_level_ctrl: directed vector table, hand sequences, randomized run vs. a level model.
module tb_reservoir_level_ctrl;
  localparam int N  = 3;
  localparam int DC = 4;
  localparam int LW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  s = '0;
  logic          fault_clr = 1'b0;
  logic [N-1:0]  fr;
  logic          dfr;
  logic [LW-1:0] level;
  logic          fault;

  int checks = 0;
  int failures = 0;

  reservoir_level_ctrl #(.NUM_LEVELS(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .s(s), .fault_clr(fault_clr),
    .fr(fr), .dfr(dfr), .level(level), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] s;
    logic         clr;
    int           lvl;
    logic [N-1:0] fr;
    logic         dfr;
    logic         flt;
  } vec_t;

  // Reference model state, in plain integers.
  int m_lvl, m_down, m_flt, m_cnt, m_dir;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] sv, input logic c);
    reset = r; s = sv; fault_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic check_all(input string tag, input int lv, input logic [N-1:0] f,
                           input logic d, input logic ft);
    chk({tag, ".level"}, int'(level), lv);
    chk({tag, ".fr"},    int'(fr),    int'(f));
    chk({tag, ".dfr"},   int'(dfr),   int'(d));
    chk({tag, ".fault"}, int'(fault), int'(ft));
  endtask

  function automatic logic [N-1:0] fr_of(input int lv);
    return N'((1 << (N - lv)) - 1);
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] sv, input logic c);
    int t;
    t = $countones(sv);
    if (r) begin
      m_lvl = 0; m_down = 1; m_flt = 0; m_cnt = 0; m_dir = 0;
    end else if (int'(sv) != (1 << t) - 1) begin
      m_flt = 1; m_cnt = 0;
    end else begin
      if (c) m_flt = 0;
      if (t == m_lvl) m_cnt = 0;
      else begin
        int d;
        bit go;
        d = (t > m_lvl) ? 1 : 0;
`ifdef RESERVOIR_DEBOUNCE_EN
        go = 0;
        if (m_cnt > 0 && d != m_dir) m_cnt = 0;
        else begin
          m_dir = d; m_cnt++;
          if (m_cnt == DC) begin go = 1; m_cnt = 0; end
        end
`else
        go = 1;
`endif
        if (go) begin
          m_lvl  = d ? m_lvl + 1 : m_lvl - 1;
          m_down = 1 - d;
        end
      end
    end
  endtask

  vec_t vt[$];

  initial begin
`ifndef RESERVOIR_DEBOUNCE_EN
    vt.push_back('{1'b1, 3'b000, 1'b0, 0, 3'b111, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b111, 1'b0, 1, 3'b011, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b111, 1'b0, 2, 3'b001, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b111, 1'b0, 3, 3'b000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b111, 1'b0, 3, 3'b000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b011, 1'b0, 2, 3'b001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b111, 1'b0, 3, 3'b000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b001, 1'b0, 2, 3'b001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b001, 1'b0, 1, 3'b011, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b101, 1'b0, 1, 3'b011, 1'b1, 1'b1});
    vt.push_back('{1'b0, 3'b011, 1'b0, 2, 3'b001, 1'b0, 1'b1});
    vt.push_back('{1'b0, 3'b101, 1'b1, 2, 3'b001, 1'b0, 1'b1});
    vt.push_back('{1'b0, 3'b011, 1'b1, 2, 3'b001, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b111, 1'b0, 3, 3'b000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b011, 1'b0, 2, 3'b001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b010, 1'b0, 2, 3'b001, 1'b1, 1'b1});
    vt.push_back('{1'b1, 3'b111, 1'b0, 0, 3'b111, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b000, 1'b0, 0, 3'b111, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b000, 1'b0, 0, 3'b111, 1'b1, 1'b0});
    vt.push_back('{1'b0, 3'b100, 1'b1, 0, 3'b111, 1'b1, 1'b1});
    vt.push_back('{1'b0, 3'b001, 1'b0, 1, 3'b011, 1'b0, 1'b1});
    vt.push_back('{1'b0, 3'b000, 1'b1, 0, 3'b111, 1'b1, 1'b0});
`endif
    repeat (2) @(posedge clk);
    #1;
    foreach (vt[k]) begin
      apply(vt[k].rst, vt[k].s, vt[k].clr);
      check_all($sformatf("vec%0d", k), vt[k].lvl, vt[k].fr, vt[k].dfr, vt[k].flt);
    end

`ifdef RESERVOIR_DEBOUNCE_EN
    // Held request steps only on the DC-th consecutive edge.
    apply(1'b1, 3'b000, 1'b0);
    check_all("db.rst", 0, 3'b111, 1'b1, 1'b0);
    for (int k = 1; k < DC; k++) begin
      apply(1'b0, 3'b001, 1'b0);
      check_all($sformatf("db.hold%0d", k), 0, 3'b111, 1'b1, 1'b0);
    end
    apply(1'b0, 3'b001, 1'b0);
    check_all("db.step", 1, 3'b011, 1'b0, 1'b0);
    // Interrupted run is discarded.
    apply(1'b1, 3'b000, 1'b0);
    apply(1'b0, 3'b001, 1'b0);
    apply(1'b0, 3'b001, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    check_all("db.abort", 0, 3'b111, 1'b1, 1'b0);
    for (int k = 1; k < DC; k++) apply(1'b0, 3'b001, 1'b0);
    check_all("db.recount", 0, 3'b111, 1'b1, 1'b0);
    apply(1'b0, 3'b001, 1'b0);
    check_all("db.recount_step", 1, 3'b011, 1'b0, 1'b0);
`else
    // Full jump up then straight down, one step per edge.
    apply(1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= N; k++) begin
      apply(1'b0, 3'b111, 1'b0);
      check_all($sformatf("jump_up%0d", k), k, fr_of(k), 1'b0, 1'b0);
    end
    for (int k = N - 1; k >= 0; k--) begin
      apply(1'b0, 3'b000, 1'b0);
      check_all($sformatf("jump_dn%0d", k), k, fr_of(k), 1'b1, 1'b0);
    end
`endif

    // Randomized run against the model.
    apply(1'b1, 3'b000, 1'b0);
    model_step(1'b1, 3'b000, 1'b0);
    for (int k = 0; k < 600; k++) begin
      logic          r, c;
      logic [N-1:0]  sv;
      int            t;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) sv = N'($urandom);
      else begin
        t  = $urandom_range(0, N);
        sv = N'((1 << t) - 1);
      end
      // Hold s for a few edges so debounced steps actually happen.
      for (int h = 0; h < int'($urandom_range(1, DC + 1)); h++) begin
        apply(r, sv, c);
        model_step(r, sv, c);
        check_all("rand", m_lvl, fr_of(m_lvl), (m_down == 1) && (m_lvl != N), m_flt[0]);
        r = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
